// File: rtl/axis_frame_len_pkg.sv
// Shared types and the length classifier used by the frame-length FIFO.
package axis_frame_len_pkg;

  localparam int unsigned LEN_FLAGS_W = 2;

  typedef struct packed {
    logic oversize;
    logic runt;
  } len_flags_t;

  // Callers zero-extend LEN_WIDTH-bit operands so the compare stays unsigned at that width.
  function automatic len_flags_t classify_len(input logic [31:0] len,
                                              input logic [31:0] min_len,
                                              input logic [31:0] max_len);
    len_flags_t flags;
    flags.runt     = (len < min_len);
    flags.oversize = (len > max_len);
    return flags;
  endfunction

endpackage

// File: rtl/axis_frame_len_fifo_ram.sv
// Simple dual-port record storage: synchronous write, asynchronous read.
module axis_frame_len_fifo_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 18,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_frame_len_fifo.sv
// Queues classified frame lengths and presents them as an AXI-stream record with a registered head.
// Optional statistics block enabled by defining AXIS_FRAME_LEN_FIFO_STATS_EN.
module axis_frame_len_fifo
  import axis_frame_len_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 1518
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LEN_WIDTH-1:0]     frame_len,
  input  logic                     frame_len_valid,
  output logic [LEN_WIDTH-1:0]     m_len_tdata,
  output logic [LEN_FLAGS_W-1:0]   m_len_tuser,
  output logic                     m_len_tvalid,
  input  logic                     m_len_tready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
`ifdef AXIS_FRAME_LEN_FIFO_STATS_EN
  input  logic                     stat_clear,
  output logic [31:0]              stat_frames,
  output logic [LEN_WIDTH-1:0]     stat_min_len,
  output logic [LEN_WIDTH-1:0]     stat_max_len,
  output logic [31:0]              stat_runts,
  output logic [31:0]              stat_oversize,
`endif
  output logic [31:0]              drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned RW = LEN_WIDTH + LEN_FLAGS_W;

  localparam logic [LEN_WIDTH-1:0] MinLenW = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MaxLenW = LEN_WIDTH'(MAX_LEN);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [RW-1:0] head_q, head_d;
  logic          overflow_q;
  logic [31:0]   drop_count_q;

  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  len_flags_t    in_flags;
  logic [RW-1:0] push_rec;
  logic [RW-1:0] rd_data;

  assign in_flags = classify_len(32'(frame_len), 32'(MinLenW), 32'(MaxLenW));
  assign push_rec = {in_flags, frame_len};

  // Occupancy and handshake decode.
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = m_len_tvalid & m_len_tready;
    push     = frame_len_valid & (~full | pop);
    drop     = frame_len_valid & full & ~pop;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  // The head register shows the entry at rd_ptr_d; when that slot is being written this cycle
  // the RAM does not hold it yet, so forward the incoming record.
  always_comb begin
    head_d = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      if (rd_ptr_d == wr_ptr_q) begin
        head_d = push_rec;
      end else begin
        head_d = rd_data;
      end
    end
  end

  axis_frame_len_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (push_rec),
    .raddr (rd_ptr_d[AW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_q       <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      head_q     <= head_d;
      overflow_q <= drop;
      if (drop && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + 32'd1;
      end
    end
  end

  assign count        = wr_ptr_q - rd_ptr_q;
  assign m_len_tvalid = (count != '0);
  assign m_len_tdata  = head_q[LEN_WIDTH-1:0];
  assign m_len_tuser  = head_q[RW-1:LEN_WIDTH];
  assign overflow     = overflow_q;
  assign drop_count   = drop_count_q;

`ifdef AXIS_FRAME_LEN_FIFO_STATS_EN
  logic [31:0]          stat_frames_q;
  logic [LEN_WIDTH-1:0] stat_min_q;
  logic [LEN_WIDTH-1:0] stat_max_q;
  logic [31:0]          stat_runts_q;
  logic [31:0]          stat_oversize_q;

  // Every pulse counts, dropped or not; a coincident clear discards the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_q   <= '0;
      stat_min_q      <= '1;
      stat_max_q      <= '0;
      stat_runts_q    <= '0;
      stat_oversize_q <= '0;
    end else if (stat_clear) begin
      stat_frames_q   <= '0;
      stat_min_q      <= '1;
      stat_max_q      <= '0;
      stat_runts_q    <= '0;
      stat_oversize_q <= '0;
    end else if (frame_len_valid) begin
      if (stat_frames_q != '1) begin
        stat_frames_q <= stat_frames_q + 32'd1;
      end
      if (frame_len < stat_min_q) begin
        stat_min_q <= frame_len;
      end
      if (frame_len > stat_max_q) begin
        stat_max_q <= frame_len;
      end
      if (in_flags.runt && (stat_runts_q != '1)) begin
        stat_runts_q <= stat_runts_q + 32'd1;
      end
      if (in_flags.oversize && (stat_oversize_q != '1)) begin
        stat_oversize_q <= stat_oversize_q + 32'd1;
      end
    end
  end

  assign stat_frames   = stat_frames_q;
  assign stat_min_len  = stat_min_q;
  assign stat_max_len  = stat_max_q;
  assign stat_runts    = stat_runts_q;
  assign stat_oversize = stat_oversize_q;
`endif

endmodule

// File: tb/tb_axis_frame_len_fifo.sv
// Directed and randomized bench for axis_frame_len_fifo against a queue-based reference model.
module tb_axis_frame_len_fifo;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] frame_len;
  logic        frame_len_valid;
  logic [15:0] m_len_tdata;
  logic [1:0]  m_len_tuser;
  logic        m_len_tvalid;
  logic        m_len_tready;
  logic [4:0]  count;
  logic        overflow;
  logic [31:0] drop_count;
`ifdef AXIS_FRAME_LEN_FIFO_STATS_EN
  logic        stat_clear;
  logic [31:0] stat_frames;
  logic [15:0] stat_min_len;
  logic [15:0] stat_max_len;
  logic [31:0] stat_runts;
  logic [31:0] stat_oversize;
`endif

  axis_frame_len_fifo #(
    .DEPTH     (DEPTH),
    .LEN_WIDTH (16),
    .MIN_LEN   (64),
    .MAX_LEN   (1518)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_len       (frame_len),
    .frame_len_valid (frame_len_valid),
    .m_len_tdata     (m_len_tdata),
    .m_len_tuser     (m_len_tuser),
    .m_len_tvalid    (m_len_tvalid),
    .m_len_tready    (m_len_tready),
    .count           (count),
    .overflow        (overflow),
`ifdef AXIS_FRAME_LEN_FIFO_STATS_EN
    .stat_clear      (stat_clear),
    .stat_frames     (stat_frames),
    .stat_min_len    (stat_min_len),
    .stat_max_len    (stat_max_len),
    .stat_runts      (stat_runts),
    .stat_oversize   (stat_oversize),
`endif
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] len;
    logic [1:0]  user;
  } rec_t;

  rec_t        model_q[$];
  logic        exp_ovf;
  int unsigned exp_drops;
  int unsigned n_checks;
  int unsigned n_pass;
`ifdef AXIS_FRAME_LEN_FIFO_STATS_EN
  int unsigned exp_frames, exp_runts, exp_ovs;
  logic [15:0] exp_min, exp_max;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_ovf   = 1'b0;
    exp_drops = 0;
`ifdef AXIS_FRAME_LEN_FIFO_STATS_EN
    exp_frames = 0; exp_runts = 0; exp_ovs = 0;
    exp_min = 16'hFFFF; exp_max = 16'h0000;
`endif
  endtask

  task automatic check_outputs();
    check("tvalid", 32'(m_len_tvalid), 32'(model_q.size() != 0));
    check("count", 32'(count), 32'(model_q.size()));
    if (model_q.size() != 0) begin
      check("tdata", 32'(m_len_tdata), 32'(model_q[0].len));
      check("tuser", 32'(m_len_tuser), 32'(model_q[0].user));
    end
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("drop_count", drop_count, exp_drops);
`ifdef AXIS_FRAME_LEN_FIFO_STATS_EN
    check("stat_frames", stat_frames, exp_frames);
    check("stat_min", 32'(stat_min_len), 32'(exp_min));
    check("stat_max", 32'(stat_max_len), 32'(exp_max));
    check("stat_runts", stat_runts, exp_runts);
    check("stat_oversize", stat_oversize, exp_ovs);
`endif
  endtask

  // One clock: drive inputs, advance the model, then check just after the edge.
  task automatic cycle(input logic v, input logic [15:0] len, input logic rdy);
    bit   pop, was_full;
    rec_t r;
    frame_len_valid = v;
    frame_len       = len;
    m_len_tready    = rdy;
    pop      = (model_q.size() != 0) && rdy;
    was_full = (model_q.size() == DEPTH);
    if (pop) r = model_q.pop_front();
    if (v && (!was_full || pop)) begin
      r.len  = len;
      r.user = {len > 16'd1518, len < 16'd64};
      model_q.push_back(r);
    end
    exp_ovf = v && was_full && !pop;
    if (exp_ovf) exp_drops++;
`ifdef AXIS_FRAME_LEN_FIFO_STATS_EN
    if (stat_clear) begin
      exp_frames = 0; exp_runts = 0; exp_ovs = 0;
      exp_min = 16'hFFFF; exp_max = 16'h0000;
    end else if (v) begin
      exp_frames++;
      if (len < exp_min) exp_min = len;
      if (len > exp_max) exp_max = len;
      if (len < 16'd64) exp_runts++;
      if (len > 16'd1518) exp_ovs++;
    end
`endif
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [15:0] rand_len();
    logic [15:0] picks [6];
    picks = '{16'd0, 16'd63, 16'd64, 16'd1518, 16'd1519, 16'hFFFF};
    if ($urandom_range(0, 7) == 0) return picks[$urandom_range(0, 5)];
    return 16'($urandom_range(0, 2100));
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n           = 1'b0;
    frame_len       = '0;
    frame_len_valid = 1'b0;
    m_len_tready    = 1'b0;
`ifdef AXIS_FRAME_LEN_FIFO_STATS_EN
    stat_clear = 1'b0;
`endif
    model_reset();

    // Reset state.
    #3;
    check("rst_tdata", 32'(m_len_tdata), 32'h0);
    check("rst_tuser", 32'(m_len_tuser), 32'h0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Classification and in-order delivery.
    cycle(1'b1, 16'd100, 1'b1);
    cycle(1'b1, 16'd60, 1'b1);
    cycle(1'b1, 16'd2000, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'd0, 1'b1);

    // Fill, overflow on the 17th, then drain.
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(64 + i), 1'b0);
    check("full_count", 32'(count), 32'd16);
    cycle(1'b1, 16'd500, 1'b0);
    cycle(1'b0, 16'd0, 1'b0);
    check("drops_after_ovf", drop_count, 32'd1);
    for (int i = 0; i < 18; i++) cycle(1'b0, 16'd0, 1'b1);

    // Full FIFO accepts a push when a pop happens in the same cycle.
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(300 + i), 1'b0);
    cycle(1'b1, 16'd200, 1'b1);
    check("full_pushpop_count", 32'(count), 32'd16);
    for (int i = 0; i < 18; i++) cycle(1'b0, 16'd0, 1'b1);

    // Toggling ready under back-to-back pulses.
    for (int i = 0; i < 24; i++) cycle(1'b1, 16'(1000 + 7 * i), 1'(i % 2));
    for (int i = 0; i < 30; i++) cycle(1'b0, 16'd0, 1'b1);

    // Reset with entries queued.
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(40 + i), 1'b0);
    rst_n = 1'b0;
    frame_len_valid = 1'b0;
    #1;
    check("async_rst_tvalid", 32'(m_len_tvalid), 32'h0);
    check("async_rst_count", 32'(count), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

`ifdef AXIS_FRAME_LEN_FIFO_STATS_EN
    cycle(1'b1, 16'd64, 1'b1);
    cycle(1'b1, 16'd1519, 1'b1);
    cycle(1'b1, 16'd10, 1'b1);
    check("st_frames3", stat_frames, 32'd3);
    check("st_min10", 32'(stat_min_len), 32'd10);
    check("st_max1519", 32'(stat_max_len), 32'd1519);
    check("st_runts1", stat_runts, 32'd1);
    check("st_ovs1", stat_oversize, 32'd1);
    stat_clear = 1'b1;
    cycle(1'b1, 16'd300, 1'b1);
    stat_clear = 1'b0;
    check("st_clr_frames", stat_frames, 32'd0);
    check("st_clr_min", 32'(stat_min_len), 32'hFFFF);
    check("st_clr_max", 32'(stat_max_len), 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'd0, 1'b1);
`endif

    // Randomized traffic: slow consumer first to exercise full/drop, then fast.
    for (int i = 0; i < 800; i++) begin
      logic v, r;
      v = ($urandom_range(0, 9) < 6);
      r = (i < 400) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
`ifdef AXIS_FRAME_LEN_FIFO_STATS_EN
      stat_clear = ($urandom_range(0, 99) == 0);
`endif
      cycle(v, rand_len(), r);
    end
`ifdef AXIS_FRAME_LEN_FIFO_STATS_EN
    stat_clear = 1'b0;
`endif
    for (int i = 0; i < 20; i++) cycle(1'b0, 16'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
